uart_rx_buffered: RTL and testbench
===================================

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 217, clock cycles per serial bit; legal minimum 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port i_RX_Ready  input  1  consumer accepts the head byte.
REQ-007 SHALL have port o_RX_Data_Valid  output  1  head entry available.
REQ-008 SHALL have port o_RX_Byte  output  8  head entry data.
REQ-009 SHALL have port o_RX_Frame_Err  output  1  head entry had a bad stop bit.
REQ-010 SHALL have port o_Overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-011 SHALL have port o_RX_Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL pass i_RX_Serial through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, LINE_WAIT.
REQ-014 SHALL count bit phase 0..CLOCKS_PER_BIT-1; M = (CLOCKS_PER_BIT-1)/2.
REQ-015 SHALL sample at phase M-1, M and M+1, and decide the bit by 2-of-3 majority at M+1.
REQ-016 IDLE: synchronized line 0 -> START with phase 0.
REQ-017 START: majority 1 -> IDLE (glitch reject, no push); at phase CLOCKS_PER_BIT-1 -> DATA.
REQ-018 DATA: 8 bits, LSB first; after bit 7 ends -> STOP.
REQ-019 STOP, decision cycle: push {byte, err}; majority 1 -> err=0 and IDLE; majority 0 -> err=1 and LINE_WAIT.
REQ-020 LINE_WAIT: stay until synchronized line is 1, then -> IDLE; no start is detected while low (break tolerance).
REQ-021 FIFO output: o_RX_Data_Valid = not empty; o_RX_Byte and o_RX_Frame_Err show the head entry.
REQ-022 A pop SHALL occur when o_RX_Data_Valid and i_RX_Ready are both high in the same cycle.
REQ-023 Latency: with the FIFO empty, o_RX_Data_Valid SHALL rise on the cycle after the STOP decision cycle.
REQ-024 Push while full without a same-cycle pop: new byte dropped, o_Overrun high exactly one cycle, contents unchanged.
REQ-025 Push and pop in the same cycle while full: both happen and o_Overrun stays low.
REQ-026 Push and pop in the same cycle while empty: no bypass; the byte is stored and valid next cycle.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be decided by an occupancy count of width $clog2(FIFO_DEPTH)+1.
REQ-028 Phase counter width SHALL be $clog2(CLOCKS_PER_BIT); the bit index SHALL be 3 bits.

Reset
REQ-029 On rst_n low: FSM -> IDLE, counters 0, FIFO empty, synchronizer flops 1.
REQ-030 On rst_n low: o_RX_Data_Valid=0, o_RX_Byte=0, o_RX_Frame_Err=0, o_Overrun=0, o_RX_Busy=0.
REQ-031 Reset mid-frame SHALL discard the partial byte; reception resumes at the next falling edge after release.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state enum, the default CLOCKS_PER_BIT constant and the FIFO entry struct {byte, frame_err}.
REQ-033 The FIFO SHALL be a separate sub-module uart_rx_fifo, parameterized by depth and entry type; the FSM stays in uart_rx_buffered.

Verification (bench with CLOCKS_PER_BIT=16, M=7, i_RX_Ready=1 unless stated)
REQ-034 Send frame 0xA5 with stop=1 -> one valid cycle, byte 0xA5, err 0, o_Overrun 0.
REQ-035 Drive the line low for 3 clocks, then high -> no valid, o_RX_Busy returns 0, FSM in IDLE.
REQ-036 Send 0x3C with stop=0, then hold the line low for 20 bit times, then high -> exactly one entry, 0x3C with err 1; no further bytes.
REQ-037 Hold i_RX_Ready=0 and send 0x01..0x05 -> o_Overrun pulses once, on the 5th stop decision; draining yields 0x01..0x04.
REQ-038 Send 0x5A and invert the line for 1 clock at phase 7 of bit 2 -> 0x5A received, err 0 (majority correction).
REQ-039 Assert rst_n during DATA bit 3 of 0xFF, release, then send 0x81 -> only 0x81 received; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default bit timing,
// buffered entry layout and the 2-of-3 vote used for bit decisions.
package uart_pkg;

  localparam int unsigned CLOCKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    LINE_WAIT = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       frame_err;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-entry FIFO for the UART receiver.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   push         - write push_data this cycle
//   push_data    - entry to store
//   pop_req      - consumer ready; pops the head when valid
//   valid        - FIFO not empty
//   head         - oldest stored entry
//   overrun      - one-cycle pulse, registered, when a push is dropped
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. There is no bypass: a push into an empty FIFO is visible next cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [8:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop_req,
  output logic   valid,
  output entry_t head,
  output logic   overrun
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overrun_q, overrun_d;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_FULL);
    do_pop    = pop_req && !empty;
    do_push   = push && (!full || do_pop);
    overrun_d = push && full && !do_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers wrap naturally: DEPTH is a power of two.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = !empty;
  assign head    = mem_q[rd_ptr_q];
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, LSB first) with a small output FIFO.
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   i_RX_Serial      - asynchronous serial input, idle high
//   i_RX_Ready       - consumer accepts the head entry
//   o_RX_Data_Valid  - head entry available
//   o_RX_Byte        - head entry data
//   o_RX_Frame_Err   - head entry had a bad stop bit
//   o_Overrun        - one-cycle pulse when a received byte is dropped
//   o_RX_Busy        - receiver FSM is not idle
// Each bit is sampled at phases MID-1, MID and MID+1 of the bit period and
// decided by a 2-of-3 vote at MID+1.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_RX_Serial,
  input  logic       i_RX_Ready,
  output logic       o_RX_Data_Valid,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_Overrun,
  output logic       o_RX_Busy
);

  localparam int unsigned PH_W = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned MID  = (CLOCKS_PER_BIT - 1) / 2;

  localparam logic [PH_W-1:0] PH_EARLY = PH_W'(MID - 1);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(MID);
  localparam logic [PH_W-1:0] PH_LATE  = PH_W'(MID + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLOCKS_PER_BIT - 1);

  logic            sync_meta_q, sync_meta_d;
  logic            sync_q, sync_d;
  rx_state_t       state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            samp_early_q, samp_early_d;
  logic            samp_mid_q, samp_mid_d;

  logic       rx_line;
  logic       bit_vote;
  logic       at_last;
  logic       push;
  rx_entry_t  push_entry;
  rx_entry_t  head_entry;

  assign rx_line = sync_q;

  always_comb begin
    sync_meta_d  = i_RX_Serial;
    sync_d       = sync_meta_q;

    state_d      = state_q;
    phase_d      = phase_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    samp_early_d = samp_early_q;
    samp_mid_d   = samp_mid_q;
    push         = 1'b0;
    push_entry   = '0;

    bit_vote = majority3(samp_early_q, samp_mid_q, rx_line);
    at_last  = (phase_q == PH_LAST);

    // Bit-timed states share the phase counter and the vote samplers.
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      phase_d = at_last ? '0 : phase_q + PH_W'(1);
      if (phase_q == PH_EARLY) samp_early_d = rx_line;
      if (phase_q == PH_MID)   samp_mid_d   = rx_line;
    end

    case (state_q)
      IDLE: begin
        phase_d   = '0;
        bit_idx_d = '0;
        if (!rx_line) state_d = START;
      end
      START: begin
        if (phase_q == PH_LATE && bit_vote) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (at_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (phase_q == PH_LATE) shift_d = {bit_vote, shift_q[7:1]};
        if (at_last) begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // The frame is committed at the stop-bit vote, not at the end of
        // the stop bit, so the next start edge is never missed.
        if (phase_q == PH_LATE) begin
          push                 = 1'b1;
          push_entry.data      = shift_q;
          push_entry.frame_err = !bit_vote;
          state_d              = bit_vote ? IDLE : LINE_WAIT;
          phase_d              = '0;
        end
      end
      LINE_WAIT: begin
        // A held-low line (break) must return high before a new start.
        phase_d = '0;
        if (rx_line) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q  <= 1'b1;
      sync_q       <= 1'b1;
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_early_q <= 1'b0;
      samp_mid_q   <= 1'b0;
    end else begin
      sync_meta_q  <= sync_meta_d;
      sync_q       <= sync_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp_early_q <= samp_early_d;
      samp_mid_q   <= samp_mid_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rx_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop_req   (i_RX_Ready),
    .valid     (o_RX_Data_Valid),
    .head      (head_entry),
    .overrun   (o_Overrun)
  );

  assign o_RX_Byte      = head_entry.data;
  assign o_RX_Frame_Err = head_entry.frame_err;
  assign o_RX_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered with CLOCKS_PER_BIT=16, depth 4.
// Frames are driven one clock slot at a time; slot s of a frame is driven
// 1 time unit after the s-th rising edge counted from the frame start.
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int MID   = (CPB - 1) / 2;
  // Two synchronizer stages plus the IDLE->START edge put DUT phase p of
  // frame bit k at slot 3+16k+p; it samples the line driven in slot 16k+p+1.
  localparam int LAT       = 3 + 9 * CPB + MID + 2;  // frame start -> valid
  localparam int DEC_SLOT  = LAT - 1;                // stop-bit vote cycle
  localparam int INV_SLOT  = 3 * CPB + MID + 1;      // DUT phase MID of data bit 2
  localparam int RST_SLOT  = 4 * CPB + 8;            // inside data bit 3

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic       rdy;
  logic       o_RX_Data_Valid;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Frame_Err;
  logic       o_Overrun;
  logic       o_RX_Busy;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_RX_Serial     (rx_line),
    .i_RX_Ready      (rdy),
    .o_RX_Data_Valid (o_RX_Data_Valid),
    .o_RX_Byte       (o_RX_Byte),
    .o_RX_Frame_Err  (o_RX_Frame_Err),
    .o_Overrun       (o_Overrun),
    .o_RX_Busy       (o_RX_Busy)
  );

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [8:0] e_ent, o_ent;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int valid_cycles = 0;
  int ovr_count    = 0;
  int ovr_cyc      = -1;
  int first_valid_cyc = -1;
  int frame_cyc    = 0;
  logic valid_prev = 1'b0;
  logic [11:0] rst_snap;
  logic busy_pre;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every accepted entry and counts pulses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_RX_Data_Valid && rdy) obs_q.push_back({o_RX_Byte, o_RX_Frame_Err});
      if (o_RX_Data_Valid) valid_cycles++;
      if (o_RX_Data_Valid && !valid_prev) first_valid_cyc = cyc;
      if (o_Overrun) begin
        ovr_count++;
        ovr_cyc = cyc;
      end
      valid_prev = o_RX_Data_Valid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int inv_slot, input int rdy_slot, input int rst_slot);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int s = 0; s < 10 * CPB; s++) begin
      @(posedge clk); #1;
      if (s == 0) frame_cyc = cyc;
      rx_line = bits[s / CPB] ^ (s == inv_slot);
      if (rdy_slot >= 0) rdy = (s == rdy_slot);
      if (s == rst_slot) begin
        busy_pre = o_RX_Busy;
        rst_n = 1'b0;
        #1;
        rst_snap = {o_RX_Data_Valid, o_RX_Byte, o_RX_Frame_Err, o_Overrun, o_RX_Busy};
      end
      if (rst_slot >= 0 && s == rst_slot + 3) rst_n = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_line = 1'b1; rdy = 1'b1;
    idle_cycles(3);
    n_checks++;
    if ({o_RX_Data_Valid, o_RX_Byte, o_RX_Frame_Err, o_Overrun, o_RX_Busy} !== 12'h000)
      $display("FAIL reset_outputs: got %h expected 000",
               {o_RX_Data_Valid, o_RX_Byte, o_RX_Frame_Err, o_Overrun, o_RX_Busy});
    else n_pass++;
    rst_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_single_frame();
    int v0, o0;
    exp_q.delete(); obs_q.delete();
    v0 = valid_cycles; o0 = ovr_count; first_valid_cyc = -1;
    exp_q.push_back({8'hA5, 1'b0});
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    idle_cycles(20);
    n_checks++;
    if (first_valid_cyc !== frame_cyc + LAT)
      $display("FAIL single_latency: got %0d expected %0d", first_valid_cyc - frame_cyc, LAT);
    else n_pass++;
    n_checks++;
    if (valid_cycles - v0 !== 1)
      $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0);
    else n_pass++;
    n_checks++;
    if (ovr_count - o0 !== 0)
      $display("FAIL single_overrun: got %0d expected 0", ovr_count - o0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL single_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL single_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int v0;
    logic busy_mid;
    exp_q.delete(); obs_q.delete();
    v0 = valid_cycles; busy_mid = 1'b0;
    for (int s = 0; s < 40; s++) begin
      @(posedge clk); #1;
      rx_line = (s < 3) ? 1'b0 : 1'b1;
      if (s == 5) busy_mid = o_RX_Busy;
    end
    n_checks++;
    if (busy_mid !== 1'b1) $display("FAIL glitch_busy_mid: got %b expected 1", busy_mid);
    else n_pass++;
    n_checks++;
    if (o_RX_Busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", o_RX_Busy);
    else n_pass++;
    n_checks++;
    if (valid_cycles - v0 !== 0)
      $display("FAIL glitch_valid: got %0d expected 0", valid_cycles - v0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL glitch_count: got %0d expected 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_frame_error();
    int v0;
    logic busy_hold;
    exp_q.delete(); obs_q.delete();
    v0 = valid_cycles;
    exp_q.push_back({8'h3C, 1'b1});
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    for (int i = 0; i < 20 * CPB; i++) begin
      @(posedge clk); #1;
      rx_line = 1'b0;
    end
    busy_hold = o_RX_Busy;
    rx_line = 1'b1;
    idle_cycles(4 * CPB);
    n_checks++;
    if (busy_hold !== 1'b1) $display("FAIL ferr_line_wait: got %b expected 1", busy_hold);
    else n_pass++;
    n_checks++;
    if (valid_cycles - v0 !== 1)
      $display("FAIL ferr_valid_cycles: got %0d expected 1", valid_cycles - v0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL ferr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL ferr_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    int o0;
    exp_q.delete(); obs_q.delete();
    o0 = ovr_count; ovr_cyc = -1;
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({i[7:0], 1'b0});
      send_frame(i[7:0], 1'b1, -1, -1, -1);
    end
    idle_cycles(10);
    n_checks++;
    if (ovr_count - o0 !== 1) $display("FAIL ovr_pulses: got %0d expected 1", ovr_count - o0);
    else n_pass++;
    n_checks++;
    if (ovr_cyc !== frame_cyc + LAT)
      $display("FAIL ovr_timing: got %0d expected %0d", ovr_cyc - frame_cyc, LAT);
    else n_pass++;
    n_checks++;
    if ({o_RX_Data_Valid, o_RX_Byte} !== {1'b1, 8'h01})
      $display("FAIL ovr_head: got %h expected 101", {o_RX_Data_Valid, o_RX_Byte});
    else n_pass++;
    rdy = 1'b1;
    idle_cycles(10);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL ovr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL ovr_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  task automatic test_full_push_pop();
    int o0;
    exp_q.delete(); obs_q.delete();
    o0 = ovr_count;
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back({8'h10 + i[7:0], 1'b0});
      send_frame(8'h10 + i[7:0], 1'b1, -1, (i == 5) ? DEC_SLOT : -1, -1);
    end
    idle_cycles(10);
    n_checks++;
    if (ovr_count - o0 !== 0) $display("FAIL fullpp_overrun: got %0d expected 0", ovr_count - o0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL fullpp_one_pop: got %0d expected 1", obs_q.size());
    else n_pass++;
    rdy = 1'b1;
    idle_cycles(10);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL fullpp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL fullpp_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  task automatic test_majority();
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({8'h5A, 1'b0});
    send_frame(8'h5A, 1'b1, INV_SLOT, -1, -1);
    idle_cycles(20);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL maj_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL maj_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_q.delete(); obs_q.delete();
    send_frame(8'hFF, 1'b1, -1, -1, RST_SLOT);
    n_checks++;
    if (busy_pre !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy_pre);
    else n_pass++;
    n_checks++;
    if (rst_snap !== 12'h000) $display("FAIL rstmid_outputs: got %h expected 000", rst_snap);
    else n_pass++;
    exp_q.push_back({8'h81, 1'b0});
    send_frame(8'h81, 1'b1, -1, -1, -1);
    idle_cycles(20);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      n_checks++;
      if (o_ent !== e_ent) $display("FAIL rstmid_entry: got %h expected %h", o_ent, e_ent);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_majority();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
